// File: rtl/fifo_wr_pipe_logic_pkg.sv
// Shared constants for the write-side pipeline register in front of a FIFO.
// Holds the occupancy encoding and small decode helpers for full/idle.
package fifo_wr_pipe_logic_pkg;

    localparam int FWP_DEFAULT_WIDTH = 8;

    // Occupancy of the two-entry register stage
    localparam logic [1:0] CNT_EMPTY = 2'd0;
    localparam logic [1:0] CNT_ONE   = 2'd1;
    localparam logic [1:0] CNT_TWO   = 2'd2;

    // Both entries occupied: the producer must be stalled
    function automatic logic cnt_is_full(input logic [1:0] cnt);
        return cnt == CNT_TWO;
    endfunction

    // No entries occupied: nothing to hand to the FIFO
    function automatic logic cnt_is_idle(input logic [1:0] cnt);
        return cnt == CNT_EMPTY;
    endfunction

endpackage

// File: rtl/fifo_wr_pipe_logic.sv
// Two-entry write pipeline between a producer and a synchronous FIFO write port.
// The producer sees a fully registered full flag, and the FIFO sees registered
// data. The only combinational input-to-output path is fifo_full -> fifo_wr_en.
module fifo_wr_pipe_logic
    import fifo_wr_pipe_logic_pkg::*;
#(
    parameter int WIDTH = FWP_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    output logic             full,
    output logic             overflow,
    output logic             idle,
    output logic [WIDTH-1:0] fifo_din,
    output logic             fifo_wr_en,
    input  logic             fifo_full
);

    logic [WIDTH-1:0] buf0_q, buf0_d;
    logic [WIDTH-1:0] buf1_q, buf1_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             full_q, full_d;
    logic             idle_q, idle_d;
    logic             overflow_q, overflow_d;
    logic             push;
    logic             pop;

    // The head entry is always what the FIFO sees; it is written whenever held and not blocked
    always_comb begin
        fifo_wr_en = (cnt_q != CNT_EMPTY) && !fifo_full;
        fifo_din   = buf0_q;
        push       = wr_en && !full_q;
        pop        = fifo_wr_en;
    end

    // Next-state for the two-entry buffer; full/idle are precomputed from the next occupancy
    always_comb begin
        buf0_d = buf0_q;
        buf1_d = buf1_q;
        cnt_d  = cnt_q;
        case ({push, pop})
            2'b10: begin
                if (cnt_q == CNT_EMPTY) begin
                    buf0_d = din;
                    cnt_d  = CNT_ONE;
                end else if (cnt_q == CNT_ONE) begin
                    buf1_d = din;
                    cnt_d  = CNT_TWO;
                end
            end
            2'b01: begin
                if (cnt_q == CNT_TWO) begin
                    buf0_d = buf1_q;
                    cnt_d  = CNT_ONE;
                end else if (cnt_q == CNT_ONE) begin
                    cnt_d  = CNT_EMPTY;
                end
            end
            2'b11: begin
                // Only reachable with one entry: the head leaves as the new word replaces it
                buf0_d = din;
                cnt_d  = CNT_ONE;
            end
            default: begin
            end
        endcase
        full_d     = cnt_is_full(cnt_d);
        idle_d     = cnt_is_idle(cnt_d);
        overflow_d = overflow_q || (wr_en && full_q);
    end

    // State registers, cleared asynchronously so outputs are quiet during reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf0_q     <= '0;
            buf1_q     <= '0;
            cnt_q      <= CNT_EMPTY;
            full_q     <= 1'b0;
            idle_q     <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            buf0_q     <= buf0_d;
            buf1_q     <= buf1_d;
            cnt_q      <= cnt_d;
            full_q     <= full_d;
            idle_q     <= idle_d;
            overflow_q <= overflow_d;
        end
    end

    assign full     = full_q;
    assign idle     = idle_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_fifo_wr_pipe_logic.sv
// Scoreboard bench for fifo_wr_pipe_logic: a queue-based model predicts flags,
// accepted words are queued as expected FIFO writes, and a monitor checks them.
module tb_fifo_wr_pipe_logic;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic [W-1:0] din;
    logic         wr_en;
    logic         full;
    logic         overflow;
    logic         idle;
    logic [W-1:0] fifo_din;
    logic         fifo_wr_en;
    logic         fifo_full;

    logic [W-1:0] model_buf[$];
    logic [W-1:0] sb_q[$];
    bit           model_ovf;
    int           checks;
    int           errors;

    fifo_wr_pipe_logic #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .wr_en      (wr_en),
        .full       (full),
        .overflow   (overflow),
        .idle       (idle),
        .fifo_din   (fifo_din),
        .fifo_wr_en (fifo_wr_en),
        .fifo_full  (fifo_full)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle, check flags against the model at the falling edge, then advance the model
    task automatic apply_stimulus(input logic wr, input logic [W-1:0] d, input logic ff);
        bit exp_pop;
        bit exp_push;
        wr_en     = wr;
        din       = d;
        fifo_full = ff;
        @(negedge clk);
        check_output("full", full, model_buf.size() == 2);
        check_output("idle", idle, model_buf.size() == 0);
        check_output("overflow", overflow, model_ovf);
        exp_pop  = (model_buf.size() != 0) && !ff;
        exp_push = wr && (model_buf.size() < 2);
        check_output("fifo_wr_en", fifo_wr_en, exp_pop);
        if (wr && model_buf.size() == 2) model_ovf = 1'b1;
        @(posedge clk);
        if (exp_pop) void'(model_buf.pop_front());
        if (exp_push) begin
            model_buf.push_back(d);
            sb_q.push_back(d);
        end
        #1;
    endtask

    // Monitor: every FIFO write must match the oldest accepted word
    always @(negedge clk) begin
        if (!rst && fifo_wr_en) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_write: got %0h expected no write at %0t", fifo_din, $time);
            end else begin
                check_output("fifo_din", fifo_din, sb_q.pop_front());
            end
        end
    end

    // Global time limit so the run always ends
    initial begin
        #2000000;
        $display("[TB] FAIL timeout: got no finish expected finish before limit");
        $fatal(1, "[TB] timeout");
    end

    // Main stimulus sequence
    initial begin
        checks    = 0;
        errors    = 0;
        model_ovf = 1'b0;
        rst       = 1'b1;
        wr_en     = 1'b0;
        din       = '0;
        fifo_full = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_output("rst_full", full, 0);
        check_output("rst_idle", idle, 1);
        check_output("rst_overflow", overflow, 0);
        check_output("rst_fifo_wr_en", fifo_wr_en, 0);
        check_output("rst_fifo_din", fifo_din, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] stream 0x01..0x10");
        for (int i = 1; i <= 16; i++) apply_stimulus(1'b1, W'(i), 1'b0);
        repeat (3) apply_stimulus(1'b0, '0, 1'b0);

        $display("[TB] backpressure from third word");
        for (int i = 0; i < 10; i++)
            apply_stimulus(1'b1, W'(8'h20 + i), (i >= 2 && i < 7));
        repeat (4) apply_stimulus(1'b0, '0, 1'b0);

        $display("[TB] overflow with 0xAA");
        apply_stimulus(1'b1, 8'h31, 1'b1);
        apply_stimulus(1'b1, 8'h32, 1'b1);
        repeat (4) apply_stimulus(1'b1, 8'hAA, 1'b1);
        repeat (4) apply_stimulus(1'b0, '0, 1'b0);

        $display("[TB] toggling fifo_full");
        for (int i = 0; i < 40; i++)
            apply_stimulus((i % 4) < 2 ? (i % 2 == 0) : 1'b1, W'(8'h40 + i), (i % 2 == 1));
        repeat (4) apply_stimulus(1'b0, '0, 1'b0);

        $display("[TB] random traffic");
        for (int i = 0; i < 10000; i++)
            apply_stimulus($urandom_range(0, 3) != 0, W'($urandom), $urandom_range(0, 2) == 0);
        repeat (4) apply_stimulus(1'b0, '0, 1'b0);
        check_output("drained", sb_q.size(), 0);

        $display("[TB] asynchronous reset with two entries held");
        repeat (3) apply_stimulus(1'b1, 8'h77, 1'b1);
        wr_en     = 1'b0;
        fifo_full = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        check_output("arst_full", full, 0);
        check_output("arst_idle", idle, 1);
        check_output("arst_fifo_wr_en", fifo_wr_en, 0);
        check_output("arst_fifo_din", fifo_din, 0);
        check_output("arst_overflow", overflow, 0);
        model_buf.delete();
        sb_q.delete();
        model_ovf = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        apply_stimulus(1'b1, 8'h5A, 1'b0);
        repeat (3) apply_stimulus(1'b0, '0, 1'b0);
        check_output("final_drained", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
